// File: rtl/branch_sequencer.sv
// Branch sequencer: accepts decoded instructions, evaluates conditional branches
// against the accumulator and advances the program counter.
module branch_sequencer #(
  parameter logic [15:0] RESET_PC = 16'h0000,
  parameter logic [15:0] PC_INC   = 16'd2
) (
  input  logic        CLK,
  input  logic        Reset,
  input  logic        InstrValid,
  output logic        InstrReady,
  input  logic        IsBranch,
  input  logic [1:0]  BranchCond,
  input  logic [15:0] BranchTarget,
  input  logic [15:0] Acc,
  input  logic        Stall,
  output logic        BranchCycle,
  output logic        BranchTaken,
  output logic [15:0] PC,
  output logic [7:0]  TakenCount
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    EVAL   = 2'd1,
    UPDATE = 2'd2
  } state_t;

  state_t      state_q, state_d;
  logic [15:0] pc_q, pc_d;
  logic [15:0] target_q, target_d;
  logic [1:0]  cond_q, cond_d;
  logic        taken_q, taken_d;
  logic [7:0]  count_q, count_d;
  logic        handshake;
  logic        cond_met;
  logic        acc_neg;
  logic        acc_zero;

  assign handshake = InstrValid && (state_q == IDLE);
  assign acc_neg   = Acc[15];
  assign acc_zero  = (Acc == 16'h0000);

  always_comb begin
    cond_met = 1'b0;
    case (cond_q)
      2'b00:   cond_met = acc_neg;
      2'b01:   cond_met = acc_zero;
      2'b10:   cond_met = !acc_zero;
      default: cond_met = !acc_neg && !acc_zero;
    endcase
  end

  always_ff @(posedge CLK or posedge Reset) begin
    if (Reset) begin
      state_q  <= IDLE;
      pc_q     <= RESET_PC;
      target_q <= 16'h0000;
      cond_q   <= 2'b00;
      taken_q  <= 1'b0;
      count_q  <= 8'h00;
    end else begin
      state_q  <= state_d;
      pc_q     <= pc_d;
      target_q <= target_d;
      cond_q   <= cond_d;
      taken_q  <= taken_d;
      count_q  <= count_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (handshake) state_d = IsBranch ? EVAL : UPDATE;
      EVAL:    state_d = UPDATE;
      UPDATE:  if (!Stall) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Datapath: capture on handshake, resolve in EVAL, commit when UPDATE is not stalled.
  always_comb begin
    pc_d     = pc_q;
    target_d = target_q;
    cond_d   = cond_q;
    taken_d  = taken_q;
    count_d  = count_q;
    case (state_q)
      IDLE: begin
        if (handshake) begin
          target_d = BranchTarget;
          cond_d   = BranchCond;
          taken_d  = 1'b0;
        end
      end
      EVAL: taken_d = cond_met;
      UPDATE: begin
        if (!Stall) begin
          pc_d = taken_q ? target_q : pc_q + PC_INC;
          if (taken_q && (count_q != 8'hFF)) count_d = count_q + 8'd1;
        end
      end
      default: ;
    endcase
  end

  always_comb begin
    InstrReady  = (state_q == IDLE);
    BranchCycle = (state_q == EVAL);
    BranchTaken = (state_q == UPDATE) && !Stall && taken_q;
  end

  assign PC         = pc_q;
  assign TakenCount = count_q;

endmodule
